// File: rtl/padder.sv
// SHA-3 / Keccak message padder: packs 32-bit words into 576-bit blocks and
// appends the domain byte plus the final 0x80. Define PADDER_KECCAK_PAD_EN for the legacy 0x01 domain byte.
module padder (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in,
  input  logic         in_ready,
  input  logic         is_last,
  input  logic [1:0]   byte_num,
  input  logic         f_ack,
  output logic         buffer_full,
  output logic [575:0] out,
  output logic         out_ready
);

`ifdef PADDER_KECCAK_PAD_EN
  localparam logic [7:0] DOMAIN = 8'h01;
`else
  localparam logic [7:0] DOMAIN = 8'h06;
`endif

  // ST_PAD is the "absorbing done" condition; ST_FINISHED parks the block after the final ack.
  typedef enum logic [1:0] {ST_ABSORB, ST_PAD, ST_FINISHED} state_e;

  state_e         state_q, state_d;
  logic [17:0]    count_q, count_d;
  logic [575:0]   out_q, out_d;
  logic           accept;
  logic           pad_shift;
  logic           last_slot;
  logic [31:0]    last_word;
  logic [31:0]    word;

  // count_q is a thermometer code: bit k set once k+1 words are held.
  assign buffer_full = count_q[17];
  assign out_ready   = count_q[17];
  assign out         = out_q;
  assign last_slot   = count_q[16];
  assign accept      = in_ready & ~buffer_full & (state_q == ST_ABSORB);
  assign pad_shift   = (state_q == ST_PAD) & ~buffer_full;

  always_comb begin
    last_word = '0;
    case (byte_num)
      2'd0: last_word = {DOMAIN, 24'h000000};
      2'd1: last_word = {in[31:24], DOMAIN, 16'h0000};
      2'd2: last_word = {in[31:16], DOMAIN, 8'h00};
      2'd3: last_word = {in[31:8], DOMAIN};
      default: last_word = '0;
    endcase
  end

  always_comb begin
    word = '0;
    if (accept) begin
      word = is_last ? last_word : in;
    end
    // Closing bit lands in whichever padded word fills the final slot.
    if (last_slot & (pad_shift | (accept & is_last))) begin
      word[7:0] = word[7:0] | 8'h80;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    out_d   = out_q;
    if (f_ack) begin
      count_d = '0;
      if ((state_q == ST_PAD) && buffer_full) begin
        state_d = ST_FINISHED;
      end
    end else if (accept | pad_shift) begin
      count_d = {count_q[16:0], 1'b1};
      out_d   = {out_q[543:0], word};
      if (accept & is_last) begin
        state_d = ST_PAD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ABSORB;
      count_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_padder.sv
// Self-checking bench for padder: directed vectors plus random messages
// compared against a byte-level padding model.
module tb_padder;

`ifdef PADDER_KECCAK_PAD_EN
  localparam logic [7:0] DOM = 8'h01;
`else
  localparam logic [7:0] DOM = 8'h06;
`endif
  localparam logic [63:0] PAIR = 64'h1234567890ABCDEF;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  in = '0;
  logic         in_ready = 1'b0;
  logic         is_last = 1'b0;
  logic [1:0]   byte_num = '0;
  logic         f_ack = 1'b0;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;

  int unsigned checks = 0;
  int unsigned fails = 0;

  padder dut (
    .clk(clk), .reset(reset), .in(in), .in_ready(in_ready), .is_last(is_last),
    .byte_num(byte_num), .f_ack(f_ack), .buffer_full(buffer_full), .out(out),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int unsigned k);
    return (k % 2 == 0) ? 32'h12345678 : 32'h90ABCDEF;
  endfunction

  task automatic do_reset();
    in_ready = 1'b0; is_last = 1'b0; f_ack = 1'b0; byte_num = '0;
    reset = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] w, input logic l, input logic [1:0] bn);
    in = w; in_ready = 1'b1; is_last = l; byte_num = bn;
    @(negedge clk);
    in_ready = 1'b0; is_last = 1'b0;
  endtask

  task automatic ack();
    f_ack = 1'b1;
    @(negedge clk);
    f_ack = 1'b0;
  endtask

  task automatic wait_full(input string name);
    for (int c = 0; c < 40 && !out_ready; c++) @(negedge clk);
    checks++;
    if (out_ready !== 1'b1) begin
      fails++; $display("FAIL %s_timeout out_ready=%b required=1", name, out_ready);
    end
  endtask

  task automatic test_reset();
    in_ready = 1'b0; f_ack = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (buffer_full !== 1'b0 || out_ready !== 1'b0 || out !== '0) begin
      fails++; $display("FAIL reset full=%b ready=%b out_nonzero=%b required 0/0/0", buffer_full, out_ready, |out);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    logic [575:0] exp;
    exp = '0; exp[575:568] = DOM; exp[7:0] = 8'h80;
    do_reset();
    in = $urandom; in_ready = 1'b1; is_last = 1'b1; byte_num = 2'd0;
    @(negedge clk); @(negedge clk);
    in_ready = 1'b0; is_last = 1'b0;
    wait_full("empty");
    checks++;
    if (out !== exp) begin
      fails++; $display("FAIL empty_block got=%h required=%h", out[63:0], exp[63:0]);
    end
    ack();
    in_ready = 1'b1; is_last = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (buffer_full !== 1'b0) begin
        fails++; $display("FAIL empty_after_ack cycle=%0d full=%b required=0", c, buffer_full);
      end
      @(negedge clk);
    end
    in_ready = 1'b0; is_last = 1'b0;
  endtask

  task automatic test_last_slot18();
    logic [575:0] exp;
    exp = {{8{PAIR}}, 56'h1234567890ABCD, DOM | 8'h80};
    do_reset();
    for (int unsigned k = 0; k < 17; k++) drive(pat(k), 1'b0, 2'd0);
    drive(32'h90ABCDEF, 1'b1, 2'd3);
    checks++;
    if (out_ready !== 1'b1 || out !== exp) begin
      fails++; $display("FAIL last_slot18 ready=%b tail=%h required ready=1 tail=%h", out_ready, out[63:0], exp[63:0]);
    end
    ack();
  endtask

  task automatic test_pad_slot18();
    logic [575:0] exp;
    exp = {{8{PAIR}}, DOM, 24'h0, 32'h00000080};
    do_reset();
    for (int unsigned k = 0; k < 16; k++) drive(pat(k), 1'b0, 2'd0);
    drive($urandom, 1'b1, 2'd0);
    checks++;
    if (out_ready !== 1'b0) begin
      fails++; $display("FAIL pad_slot18_early ready=%b required=0", out_ready);
    end
    @(negedge clk);
    checks++;
    if (out_ready !== 1'b1 || out !== exp) begin
      fails++; $display("FAIL pad_slot18 ready=%b tail=%h required ready=1 tail=%h", out_ready, out[63:0], exp[63:0]);
    end
    ack();
  endtask

  task automatic test_full_hold();
    logic [575:0] exp;
    do_reset();
    for (int unsigned k = 0; k < 18; k++) drive(pat(k), 1'b0, 2'd0);
    exp = {9{PAIR}};
    checks++;
    if (out_ready !== 1'b1 || out !== exp) begin
      fails++; $display("FAIL full_block ready=%b tail=%h required ready=1 tail=%h", out_ready, out[63:0], exp[63:0]);
    end
    in = 32'd999; in_ready = 1'b1; is_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (buffer_full !== 1'b1) begin
        fails++; $display("FAIL full_hold cycle=%0d full=%b required=1", c, buffer_full);
      end
    end
    in_ready = 1'b0;
    checks++;
    if (out !== exp) begin
      fails++; $display("FAIL full_hold_data tail=%h required=%h", out[63:0], exp[63:0]);
    end
    ack();
    checks++;
    if (out_ready !== 1'b0) begin
      fails++; $display("FAIL full_ack ready=%b required=0", out_ready);
    end
    for (int unsigned k = 0; k < 17; k++) drive(pat(k), 1'b0, 2'd0);
    drive(32'h90ABCDEF, 1'b1, 2'd2);
    exp = {{8{PAIR}}, 32'h12345678, 16'h90AB, DOM, 8'h80};
    checks++;
    if (out_ready !== 1'b1 || out !== exp) begin
      fails++; $display("FAIL second_block ready=%b tail=%h required ready=1 tail=%h", out_ready, out[63:0], exp[63:0]);
    end
    ack();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_ready !== 1'b0) begin
        fails++; $display("FAIL after_final cycle=%0d ready=%b required=0", c, out_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [575:0] exp;
    exp = '0; exp[575:568] = DOM; exp[7:0] = 8'h80;
    do_reset();
    for (int unsigned k = 0; k < 5; k++) drive($urandom, 1'b0, 2'd0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out !== '0 || buffer_full !== 1'b0) begin
      fails++; $display("FAIL async_reset out_nonzero=%b full=%b required 0/0", |out, buffer_full);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive($urandom, 1'b1, 2'd0);
    for (int c = 0; c < 16; c++) begin
      checks++;
      if (out_ready !== 1'b0) begin
        fails++; $display("FAIL reset_mid_early cycle=%0d ready=%b required=0", c, out_ready);
      end
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (out_ready !== 1'b1 || out !== exp) begin
      fails++; $display("FAIL reset_mid_block ready=%b tail=%h required ready=1 tail=%h", out_ready, out[63:0], exp[63:0]);
    end
    ack();
  endtask

  task automatic test_random(input int unsigned nmsg);
    for (int unsigned m = 0; m < nmsg; m++) begin
      logic [31:0]  words[$];
      logic [7:0]   bytes[$];
      logic [575:0] exp;
      logic [1:0]   bn;
      logic         full_prev;
      int unsigned  nfull, nblk, idx, blk, cyc;
      do_reset();
      words.delete(); bytes.delete();
      nfull = $urandom_range(0, 40);
      bn = 2'($urandom_range(0, 3));
      for (int unsigned i = 0; i <= nfull; i++) words.push_back($urandom);
      for (int unsigned i = 0; i < nfull; i++)
        for (int unsigned b = 0; b < 4; b++) bytes.push_back(8'(words[i] >> (24 - 8*b)));
      for (int unsigned b = 0; b < bn; b++) bytes.push_back(8'(words[nfull] >> (24 - 8*b)));
      bytes.push_back(DOM);
      while (bytes.size() % 72 != 0) bytes.push_back(8'h00);
      bytes[bytes.size()-1] = bytes[bytes.size()-1] | 8'h80;
      nblk = bytes.size() / 72;
      idx = 0; blk = 0; cyc = 0; full_prev = 1'b0;
      while (blk < nblk && cyc < 3000) begin
        if (in_ready && !full_prev && idx <= nfull) idx++;
        f_ack = 1'b0;
        if (out_ready) begin
          exp = '0;
          for (int unsigned k = 0; k < 72; k++) exp = {exp[567:0], bytes[blk*72 + k]};
          checks++;
          if (out !== exp) begin
            fails++; $display("FAIL random_block msg=%0d blk=%0d tail=%h required=%h", m, blk, out[63:0], exp[63:0]);
          end
          blk++;
          f_ack = 1'b1;
        end
        full_prev = buffer_full;
        if (idx <= nfull) begin
          in_ready = ($urandom_range(0, 3) != 0);
          in = words[idx];
          is_last = (idx == nfull);
          byte_num = (idx == nfull) ? bn : 2'($urandom);
        end else begin
          in_ready = 1'($urandom); in = $urandom; is_last = 1'($urandom); byte_num = 2'($urandom);
        end
        @(negedge clk);
        cyc++;
      end
      f_ack = 1'b0;
      checks++;
      if (blk != nblk) begin
        fails++; $display("FAIL random_count msg=%0d blocks=%0d required=%0d", m, blk, nblk);
      end
      for (int c = 0; c < 8; c++) begin
        in_ready = 1'($urandom); is_last = 1'($urandom); in = $urandom;
        @(negedge clk);
        checks++;
        if (out_ready !== 1'b0) begin
          fails++; $display("FAIL random_after msg=%0d cycle=%0d ready=%b required=0", m, c, out_ready);
        end
      end
      in_ready = 1'b0; is_last = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_last_slot18();
    test_pad_slot18();
    test_full_hold();
    test_reset_mid();
    test_random(12);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/padder.md
PADDER -- requirements
Module: padder

Interface
REQ-001 SHALL expose: clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL expose: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL expose: in  input  32  message word; first message byte in in[31:24].
REQ-004 SHALL expose: in_ready  input  1  in holds a valid word.
REQ-005 SHALL expose: is_last  input  1  current word is the final (possibly partial) message word.
REQ-006 SHALL expose: byte_num  input  2  valid bytes in final word (0..3, MSB-first); ignored unless is_last=1.
REQ-007 SHALL expose: f_ack  input  1  consumer has taken the current 576-bit block.
REQ-008 SHALL expose: buffer_full  output  1  block buffer holds 18 words; input not accepted.
REQ-009 SHALL expose: out  output  576  padded block; earliest word in out[575:544].
REQ-010 SHALL expose: out_ready  output  1  out holds a complete block; equals buffer_full.

Function
REQ-011 SHALL keep an 18-bit word-count/valid register, an "absorbing done" flag and a 576-bit shift register out.
REQ-012 Accept = in_ready & ~buffer_full & ~done; an accepted word shifts in: out <= {out[543:0], w}, count+1.
REQ-013 Non-last accepted word: w = in.
REQ-014 Last word (is_last=1): w = byte_num 0 -> 32'h06000000; 1 -> {in[31:24],24'h060000}; 2 -> {in[31:16],16'h0600}; 3 -> {in[31:8],8'h06}; done set same edge.
REQ-015 While done=1 and ~buffer_full, one zero pad word SHALL shift in every cycle without in_ready.
REQ-016 Any last or pad word landing in slot 18 SHALL have 8'h80 ORed into bits [7:0] (e.g. 0x06|0x80 = 0x86).
REQ-017 Padding never spans an extra block; done block completes in the current block.
REQ-018 buffer_full/out_ready SHALL rise on the edge capturing the 18th word, no extra latency.
REQ-019 While buffer_full=1, in, in_ready, is_last SHALL be ignored (no word consumed).
REQ-020 f_ack=1 at an edge SHALL clear the count (buffer_full=0 next cycle); out contents need not be cleared.
REQ-021 After f_ack of the final (done) block, no further words accepted or generated; out_ready stays 0 until reset.
REQ-022 in_ready with is_last on the cycle after done SHALL NOT be consumed.

Reset
REQ-023 reset=0 SHALL asynchronously clear count, done and out to 0; buffer_full=out_ready=0.
REQ-024 Reset mid-block SHALL discard partial block; first accept after release starts slot 1.

Configuration
REQ-025 Macro PADDER_KECCAK_PAD_EN: defined -> domain byte 8'h01 replaces 8'h06 in REQ-014 (legacy Keccak pad10*1); undefined (default) -> 8'h06 (SHA-3).

Verification
REQ-026 Empty message: reset, in_ready=1,is_last=1,byte_num=0 for 2 cycles -> out = {8'h06,560'h0,8'h80}, out_ready=1; after f_ack buffer_full=0 for >=5 cycles.
REQ-027 17 words 12345678/90ABCDEF alternating, 18th 90ABCDEF with is_last,byte_num=3 -> out = {8{64'h1234567890ABCDEF},64'h1234567890ABCD86}.
REQ-028 16 such words, then is_last,byte_num=0 -> after 2 more cycles out = {8{64'h1234567890ABCDEF},64'h0600000000000080}.
REQ-029 18 words no is_last -> out_ready=1, out={9{64'h1234567890ABCDEF}}; drive in=999 while full -> buffer_full stays 1, not consumed; f_ack -> out_ready=0.
REQ-030 Then 17 words + last 90ABCDEF byte_num=2 -> out ends 64'h1234567890AB0680; f_ack, in_ready=0 -> out_ready=0 for 10 cycles.
REQ-031 Assert reset mid-block and with PADDER_KECCAK_PAD_EN defined -> empty message yields {8'h01,560'h0,8'h80}.
